// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding and default sizing for the IMEM boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int LOADER_DEPTH  = 64;
    localparam int LOADER_ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } loader_state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic is_byte_state(input loader_state_e s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Shifts bytes into a little-endian 32-bit word (first byte lands in [7:0]).
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (load_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= {byte_i, word_q[31:8]};
        end
    end

    // Asserted alongside the byte that completes the word.
    assign word_full_o = load_i && (idx_q == 2'd3);
    assign word_o      = word_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time loader: length-prefixed byte stream -> sequential IMEM words.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DEPTH  = LOADER_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [15:0]   c_DEPTH_LEN = 16'(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_CNT_ONE   = (ADDR_W + 1)'(1);

    loader_state_e   state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [ADDR_W:0] limit_q, limit_d;
    logic [15:0]     discard_q, discard_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            w_xfer;
    logic [15:0]     w_len;
    logic [ADDR_W:0] w_cnt_inc;
    logic            w_pk_load;
    logic            w_pk_clear;
    logic            w_pk_full;
    logic [31:0]     w_pk_word;

    assign w_xfer    = byte_valid && is_byte_state(state_q);
    assign w_len     = {byte_data, len_lo_q};
    assign w_cnt_inc = cnt_q + c_CNT_ONE;

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (w_pk_clear),
        .load_i      (w_pk_load),
        .byte_i      (byte_data),
        .word_o      (w_pk_word),
        .word_full_o (w_pk_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_lo_q  <= 8'd0;
            limit_q   <= '0;
            discard_q <= 16'd0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            limit_q   <= limit_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        limit_d    = limit_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        w_pk_load  = 1'b0;
        w_pk_clear = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LEN_LO;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    discard_d  = 16'd0;
                    w_pk_clear = 1'b1;
                end
            end
            LEN_LO: begin
                if (w_xfer) begin
                    len_lo_d = byte_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_xfer) begin
                    if (w_len == 16'd0) begin
                        state_d = DONE;
                    end else if (w_len > c_DEPTH_LEN) begin
                        // Oversized image: fill IMEM, then swallow the excess words.
                        err_d     = 1'b1;
                        limit_d   = c_DEPTH_CNT;
                        discard_d = w_len - c_DEPTH_LEN;
                        state_d   = DATA;
                    end else begin
                        limit_d   = w_len[ADDR_W:0];
                        discard_d = 16'd0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                w_pk_load = w_xfer;
                if (w_pk_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q != c_DEPTH_CNT) begin
                    cnt_d = w_cnt_inc;
                end
                if (w_cnt_inc < limit_q) begin
                    state_d = DATA;
                end else if (discard_q != 16'd0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                w_pk_load = w_xfer;
                if (w_pk_full) begin
                    discard_d = discard_q - 16'd1;
                    if (discard_q == 16'd1) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_ready   = is_byte_state(state_q);
    assign imem_we      = (state_q == WRITE);
    assign imem_waddr   = cnt_q[ADDR_W-1:0];
    assign imem_wdata   = w_pk_word;
    assign core_hold    = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign err_overflow = err_q;
    assign word_count   = cnt_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. Writes the words sequentially into the IMEM write port starting at word address 0. Holds the single-cycle core (PC flop and data memory) in hold until the load completes, then releases it so fetch starts from address 0.

## Interface
- Reset is synchronous and active-high, on one clock `clk`; the reset port is `rst`.

Parameters:
- `ADDR_W`, 6, IMEM word-address width.
- `DEPTH`, 64, IMEM capacity in words; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle pulse; begins a load when idle or done.
- `byte_valid`  in  1  `byte_data` holds a byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  IMEM write strobe, one cycle per word.
- `imem_waddr`  out  ADDR_W  IMEM word address.
- `imem_wdata`  out  32  IMEM write word.
- `core_hold`  out  1  high while the core must not run.
- `done`  out  1  load finished; level, not a pulse.
- `err_overflow`  out  1  sticky; the header asked for more than DEPTH words.
- `word_count`  out  ADDR_W+1  number of words written in this load.

## Operation
- Stream format: `LEN[7:0]`, `LEN[15:8]`, then 4·LEN payload bytes. Each word's first byte goes to bits [7:0].
- A byte transfers only when `byte_valid && byte_ready`. `byte_ready` is high only in LEN_LO, LEN_HI, DATA and DRAIN.
- States:
  - IDLE: on `start`, go to LEN_LO, clear `word_count`, clear `err_overflow`, clear `done`, set `core_hold`.
  - LEN_LO: after 1 transfer, go to LEN_HI.
  - LEN_HI: after 1 transfer, latch the 16-bit LEN.
    - LEN=0: go to DONE.
    - LEN>DEPTH: set `err_overflow`, set the write limit to DEPTH, keep the discard count at LEN−DEPTH words, go to DATA.
    - Otherwise: set the write limit to LEN, go to DATA.
  - DATA: collect bytes into the packer. On the 4th byte go to WRITE.
  - WRITE: one cycle. `imem_we`=1, `imem_waddr`=`word_count`, `imem_wdata`=packed word. Then increment `word_count`.
    - Next state is DATA if `word_count`+1 < limit.
    - Otherwise DRAIN if the discard count is nonzero.
    - Otherwise DONE.
  - DRAIN: accept and discard 4·(LEN−DEPTH) bytes, then go to DONE.
  - DONE: `done`=1, `core_hold`=0. On `start`, re-enter LEN_LO with the same clears as IDLE.
- `start` is ignored in every state except IDLE and DONE.
- Byte counters are wide enough for LEN=65535 (16-bit word counter, 2-bit byte index).

## Timing
- Reset values:
  - State: IDLE.
  - `byte_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `core_hold`=1, `done`=0, `err_overflow`=0, `word_count`=0.
- `rst` mid-load aborts immediately. Words already written stay in IMEM, and the core stays held.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Best-case throughput is 5 cycles per word: 4 byte transfers plus 1 WRITE cycle.
- Cycle timing for a load:
  - `start` at edge 0 puts the loader in LEN_LO at edge 1.
  - With continuous valid, the first `imem_we` is asserted in cycle 7.
  - `core_hold` falls in the cycle after the last WRITE (or after the last DRAIN byte).
- `byte_valid` gaps stall the state machine in place with no loss of packer contents.
- `imem_waddr`/`imem_wdata` are stable throughout the WRITE cycle. `imem_we` is never asserted outside WRITE.
- `word_count` saturates at DEPTH and never wraps.

## Structure
- Shared package `loader_pkg`:
  - State enum: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DRAIN, DONE.
  - Default constants `LOADER_DEPTH`=64 and `LOADER_ADDR_W`=6.
- Sub-module `byte_packer`:
  - Ports: 2-bit byte index, 32-bit shift-in register, `load`/`clear` inputs, `word_full` output.
  - Instantiated once.
- At top level, `core_hold` is ORed into the PC flop enable and the dmem write enable.

## Test plan
- LEN=2, bytes 13 00 00 00 / 93 00 10 00 sent back-to-back → writes 0x00000013 @0 and 0x00100093 @1, `word_count`=2, `done`=1, `core_hold`=0, `err_overflow`=0.
- LEN=0 → DONE two transfers after `start`, no `imem_we`, `word_count`=0.
- LEN=65 with DEPTH=64 → 64 writes at addresses 0..63, last 4 bytes accepted and discarded, `err_overflow`=1, `word_count`=64.
- LEN=1 with `byte_valid` toggling every other cycle → single write of the correct word; `byte_ready` drops during WRITE; no byte lost or duplicated.
- `rst` asserted after the 3rd payload byte → all outputs at reset values the next cycle; a following `start` plus full stream loads correctly from address 0.
- `start` pulsed during DATA → ignored; `start` in DONE → `done` falls, `core_hold` rises, new load begins.
